// File: rtl/mux2_arb_pkg.sv
// Shared types and helpers for the two-requester round-robin mux arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  // clog2(burst_max + 1), never less than 1
  function automatic int cnt_width(input int burst_max);
    int w;
    w = 1;
    while ((1 << w) < (burst_max + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux2_bus.sv
// W-bit 2:1 data mux; s=0 passes a, s=1 passes b.
module mux2_bus #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s,
  output logic [W-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 data mux.
// Optional burst preemption is built when MUX2_ARB_PREEMPT_EN is defined.
//
// state | meaning
// IDLE  | no grant, y forced to 0
// G0    | requester 0 granted, sel=0
// G1    | requester 1 granted, sel=1
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int W         = 8,
  parameter int BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sel,
  output logic         valid,
  output logic [W-1:0] y
);

  if (BURST_MAX < 1) begin : g_bad_burst_max
    $error("mux2_arbiter: BURST_MAX must be at least 1");
  end

  state_t         state;
  state_t         state_nxt;
  logic           last;
  logic [W-1:0]   mux_y;

`ifdef MUX2_ARB_PREEMPT_EN
  localparam int CW = cnt_width(BURST_MAX);
  logic [CW-1:0] cnt;
  logic          burst_done;

  assign burst_done = (cnt == CW'(BURST_MAX));
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last ? G0 : G1;
        else if (req0)     state_nxt = G0;
        else if (req1)     state_nxt = G1;
        else               state_nxt = IDLE;
      end
      G0: begin
        if (!req0)         state_nxt = req1 ? G1 : IDLE;
`ifdef MUX2_ARB_PREEMPT_EN
        else if (req1 && burst_done) state_nxt = G1;
`endif
        else               state_nxt = G0;
      end
      G1: begin
        if (!req1)         state_nxt = req0 ? G0 : IDLE;
`ifdef MUX2_ARB_PREEMPT_EN
        else if (req0 && burst_done) state_nxt = G0;
`endif
        else               state_nxt = G1;
      end
      default:             state_nxt = IDLE;
    endcase
  end

  // Grants and select are registered copies of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      sel   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      gnt0  <= (state_nxt == G0);
      gnt1  <= (state_nxt == G1);
      sel   <= (state_nxt == G1);
      if (state_nxt == G0) last <= 1'b0;
      else if (state_nxt == G1) last <= 1'b1;
    end
  end

`ifdef MUX2_ARB_PREEMPT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_nxt == IDLE) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= CW'(1);
    end else if (!burst_done) begin
      cnt <= cnt + CW'(1);
    end
  end
`endif

  mux2_bus #(.W(W)) u_bus (
    .a (d0),
    .b (d1),
    .s (sel),
    .y (mux_y)
  );

  assign valid = gnt0 | gnt1;
  assign y     = valid ? mux_y : '0;

endmodule
